// File: rtl/tx_frame_sched.sv
// UART transmit scheduler: arbitrates two byte requesters, frames start/data/stop, paces a PISO register.
// Define TX_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module tx_frame_sched #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [9:0] frame_data,
  output logic       piso_load,
  output logic       piso_shift,
  output logic       grant_id,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] PERIOD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [3:0]       bit_cnt;
  logic             win0;
  logic             win1;
  logic             hs0;
  logic             hs1;
  logic [7:0]       sel_byte;

`ifdef TX_ARB_RR_EN
  logic last_grant;

  // With both requesters valid, the one not served last wins; reset leaves last_grant=1 so req0 goes first.
  always_comb begin
    win0 = req0_valid & (~req1_valid | last_grant);
    win1 = req1_valid & (~req0_valid | ~last_grant);
  end
`else
  always_comb begin
    win0 = req0_valid;
    win1 = req1_valid & ~req0_valid;
  end
`endif

  assign req0_ready = (state == IDLE) & win0;
  assign req1_ready = (state == IDLE) & win1;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;
  assign sel_byte   = hs1 ? req1_data : req0_data;

  // The shift register sends bit 9 first, so the data byte is stored bit-reversed.
  function automatic logic [9:0] make_frame(input logic [7:0] b);
    logic [9:0] f;
    f = 10'b0_0000_0000_1;
    for (int i = 0; i < 8; i++) f[8-i] = b[i];
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame_data <= 10'h3FF;
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      tx_done    <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      period_cnt <= '0;
      bit_cnt    <= '0;
`ifdef TX_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (hs0 | hs1) begin
            frame_data <= make_frame(sel_byte);
            grant_id   <= hs1;
            busy       <= 1'b1;
            piso_load  <= 1'b1;
            state      <= LOAD;
`ifdef TX_ARB_RR_EN
            last_grant <= hs1;
`endif
          end
        end
        LOAD: begin
          period_cnt <= PERIOD_RELOAD;
          bit_cnt    <= '0;
          state      <= SHIFT;
        end
        SHIFT: begin
          // piso_shift is registered, so it is raised one cycle early to coincide with period_cnt==0.
          if (period_cnt == '0) begin
            period_cnt <= PERIOD_RELOAD;
            bit_cnt    <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              state   <= DONE;
              tx_done <= 1'b1;
            end
          end else begin
            period_cnt <= period_cnt - CNT_W'(1);
            if (period_cnt == CNT_W'(1)) piso_shift <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Randomized bench for tx_frame_sched checked against a cycle-time model derived from handshake times.
// Honours TX_ARB_RR_EN the same way as the design.
module tb_tx_frame_sched;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready;
  logic       req1_ready;
  logic [9:0] frame_data;
  logic       piso_load;
  logic       piso_shift;
  logic       grant_id;
  logic       busy;
  logic       tx_done;

  tx_frame_sched #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .frame_data(frame_data), .piso_load(piso_load), .piso_shift(piso_shift),
    .grant_id(grant_id), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the time of the last accepted handshake determines every strobe.
  int         cyc = 0;
  int         hs_t = -100000;
  int         idle_at = 0;
  logic [9:0] m_frame = 10'h3FF;
  logic       m_grant = 1'b0;
  logic       m_last = 1'b1;
  logic       pend_reset = 1'b0;
  logic       chk_en = 1'b0;
  logic       just_reset = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic [9:0] f;
    f[9] = 1'b0;
    f[0] = 1'b1;
    for (int i = 0; i < 8; i++) f[8-i] = b[i];
    return f;
  endfunction

  task automatic applyStimulus(input logic rst, input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1);
    logic idle, e0, e1, er0, er1;
    int   d;
    @(posedge clk);
    cyc++;
    just_reset = 1'b0;
    if (pend_reset) begin
      hs_t       = -100000;
      idle_at    = cyc;
      m_frame    = 10'h3FF;
      m_grant    = 1'b0;
      m_last     = 1'b1;
      chk_en     = 1'b1;
      just_reset = 1'b1;
    end
    #1;
    reset      = rst;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
    idle = (cyc >= idle_at);
`ifdef TX_ARB_RR_EN
    e0 = v0 && (!v1 || m_last);
`else
    e0 = v0;
`endif
    e1  = v1 && !e0;
    er0 = idle && e0;
    er1 = idle && e1;
    if (chk_en) begin
      d = cyc - hs_t - 1;
      checkOutput("req0_ready", req0_ready, er0);
      checkOutput("req1_ready", req1_ready, er1);
      checkOutput("piso_load", piso_load, d == 0);
      checkOutput("piso_shift", piso_shift, (d > 0) && (d % CPB == 0) && (d / CPB <= 10));
      checkOutput("tx_done", tx_done, cyc == hs_t + 2 + 10 * CPB);
      checkOutput("busy", busy, !idle);
      if (!idle || just_reset) begin
        checkOutput("frame_data", frame_data, m_frame);
        checkOutput("grant_id", grant_id, m_grant);
      end
    end
    pend_reset = rst;
    if (!rst && (er0 || er1)) begin
      hs_t    = cyc;
      idle_at = cyc + FRAME_CYC;
      m_grant = er1;
      m_frame = frame_of(er1 ? d1 : d0);
      m_last  = er1;
    end
  endtask

  task automatic runQuiet(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

    // Single A5 frame from requester 0.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    checkOutput("a5_frame_model", {22'd0, m_frame}, {22'd0, 10'b0_10100101_1});
    runQuiet(FRAME_CYC + 2);

    // Both requesters valid continuously.
    repeat (4 * FRAME_CYC + 1) applyStimulus(1'b0, 1'b1, 8'h11, 1'b1, 8'h22);
    runQuiet(FRAME_CYC);

    // Requester 1 pulses valid only while busy.
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0, 8'h00);
    runQuiet(10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h44);
    runQuiet(FRAME_CYC + 5);

    // Back-to-back frames from requester 0 with fresh data every cycle.
    repeat (3 * FRAME_CYC) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00);
    runQuiet(FRAME_CYC);

    // Reset in the 20th cycle of SHIFT, then a fresh req1 byte.
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
    runQuiet(20);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'hFF);
    checkOutput("ff_frame_model", {22'd0, m_frame}, {22'd0, 10'b0_11111111_1});
    runQuiet(FRAME_CYC + 2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 2) == 0, 8'($urandom),
                    $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
